// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } i2c_state_e;

  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;
  localparam int         BIT_CNT_W     = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability filter for one I2C line; emits
// single-cycle rise/fall pulses on the filtered level.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_out,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILT_LEN - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      line_out <= 1'b1;
      cnt      <= CNT_LOAD;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == line_out) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        line_out <= sync[1];
        rise     <= sync[1];
        fall     <= ~sync[1];
        cnt      <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with NUM_REGS x 8 register file, auto-incrementing pointer and host port.
// Optional build macro I2C_GEN_CALL_EN: accept a general-call write into register 0.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16,
  parameter int         FILT_LEN = 3,
  localparam int        PTR_W    = $clog2(NUM_REGS)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic             busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(sys_clk), .rst(sys_rst), .line_in(scl_in),
    .line_out(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(sys_clk), .rst(sys_rst), .line_in(sda_in),
    .line_out(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e           state;
  logic [7:0]           regs [NUM_REGS];
  logic [7:0]           shift;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [PTR_W-1:0]     ptr;
  logic                 rd_wr;
  logic                 gen_call;

  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] wr_idx;

  assign rx_byte    = {shift[6:0], sda_lvl};
  assign ptr_inc    = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  assign wr_idx     = gen_call ? '0 : ptr;
  assign host_rdata = regs[host_addr];

  // ACK states use sda_oe as the phase flag: first SCL fall drives, second releases.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      ptr       <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      rd_wr     <= 1'b0;
      gen_call  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (host_we) regs[host_addr] <= host_wdata;

      if (scl_lvl && sda_fall) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        gen_call <= 1'b0;
      end else if (scl_lvl && sda_rise) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        gen_call <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_CNT_W'(7)) begin
              rd_wr <= sda_lvl;
              if (shift[6:0] == SLV_ADDR) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
              end
`ifdef I2C_GEN_CALL_EN
              else if (shift[6:0] == GEN_CALL_ADDR && !sda_lvl) begin
                state    <= ADDR_ACK;
                busy     <= 1'b1;
                gen_call <= 1'b1;
              end
`endif
              else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          PTR: begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_CNT_W'(7)) begin
              ptr   <= rx_byte[PTR_W-1:0];
              state <= PTR_ACK;
            end
          end
          WDATA: begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_CNT_W'(7)) begin
              regs[wr_idx] <= rx_byte;
              wr_strobe    <= 1'b1;
              wr_addr      <= wr_idx;
              if (!gen_call) ptr <= ptr_inc;
              state <= WDATA_ACK;
            end
          end
          RDATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_CNT_W'(7)) state <= RACK;
          end
          RACK: begin
            if (!sda_lvl) begin
              ptr     <= ptr_inc;
              shift   <= regs[ptr_inc];
              bit_cnt <= '0;
              state   <= RDATA;
            end else begin
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK: begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (rd_wr) begin
              sda_oe  <= ~regs[ptr][7];
              shift   <= {regs[ptr][6:0], 1'b0};
              bit_cnt <= '0;
              state   <= RDATA;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= gen_call ? WDATA : PTR;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= gen_call ? IGNORE : WDATA;
            end
          end
          RDATA: begin
            sda_oe <= ~shift[7];
            shift  <= {shift[6:0], 1'b0};
          end
          RACK: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Scoreboard bench: bit-level I2C master, transaction-level register model, wr_strobe monitor.
module tb_i2c_slave_regfile;

  localparam int         Q   = 8;
  localparam logic [6:0] SLV = 7'h50;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = 4'h0;
  logic [7:0] host_wdata = 8'h00;
  logic       scl_in, sda_in, sda_oe, wr_strobe, busy;
  logic [7:0] host_rdata;
  logic [3:0] wr_addr;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 sys_clk = ~sys_clk;

  i2c_slave_regfile dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .busy(busy)
  );

  int         n_cmp = 0, n_bad = 0;
  int         oe_cnt = 0;
  logic [7:0] mregs [16];
  logic [3:0] mptr = 4'h0;
  logic [3:0] exp_q [$];
  logic [7:0] wd [4];
  logic [3:0] ha;
  logic [7:0] hd;

  always @(posedge sys_clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // wr_strobe monitor: every pulse must match the oldest expected commit
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst && wr_strobe) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wr_strobe: got wr_addr 0x%0h, want no strobe", wr_addr);
        end else begin
          chk("wr_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // mode 0 plain, 1 with 1-clk SCL/SDA glitches, 2 host write on the committing clock
  task automatic bit_x(input logic b, input int mode, output logic s);
    sda_m = b;
    if (mode == 1) begin
      wclk(4); scl_m = 1'b1; wclk(1); scl_m = 1'b0; wclk(Q - 5);
    end else wclk(Q);
    scl_m = 1'b1;
    if (mode == 1) begin
      wclk(5); scl_m = 1'b0; wclk(1); scl_m = 1'b1;
      if (b) sda_m = 1'b0;
      wclk(1); sda_m = b; wclk(Q - 7);
    end else if (mode == 2) begin
      wclk(5);
      host_addr = ha; host_wdata = hd; host_we = 1'b1;
      wclk(1);
      chk("collide_strobe", 32'(wr_strobe), 32'd1);
      host_we = 1'b0;
      wclk(Q - 6);
    end else wclk(Q);
    s = sda_in;
    wclk(Q);
    scl_m = 1'b0;
    wclk(Q);
  endtask

  task automatic start_c();
    sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q); scl_m = 1'b0; wclk(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wclk(Q); scl_m = 1'b1; wclk(Q); sda_m = 1'b1; wclk(2 * Q);
  endtask

  task automatic wbyte(input logic [7:0] d, input int mode, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(d[i], (mode == 2 && i != 0) ? 0 : mode, s);
    end
    bit_x(1'b1, 0, ack);
  endtask

  task automatic rbyte(input logic ackb, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_x(1'b1, 0, s);
      d = {d[6:0], s};
    end
    bit_x(ackb, 0, s);
  endtask

  task automatic hwrite(input logic [3:0] a, input logic [7:0] d);
    @(negedge sys_clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge sys_clk);
    host_we = 1'b0;
    mregs[a] = d;
  endtask

  task automatic rchk(input logic [3:0] a, input string nm);
    host_addr = a;
    #1;
    chk(nm, 32'(host_rdata), 32'(mregs[a]));
  endtask

  task automatic t_write(input logic [7:0] pb, input int n, input int mode);
    logic a;
    start_c();
    wbyte({SLV, 1'b0}, 0, a);
    chk("addr_ack", 32'(a), 32'd0);
    chk("busy_on", 32'(busy), 32'd1);
    wbyte(pb, 0, a);
    chk("ptr_ack", 32'(a), 32'd0);
    mptr = 4'(pb % 16);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mptr);
      mregs[mptr] = wd[2'(k)];
      wbyte(wd[2'(k)], mode, a);
      chk("data_ack", 32'(a), 32'd0);
      mptr = 4'((int'(mptr) + 1) % 16);
    end
    stop_c();
    chk("busy_off", 32'(busy), 32'd0);
  endtask

  task automatic t_read(input logic setp, input logic [7:0] pb, input int n);
    logic       a;
    logic [7:0] d;
    start_c();
    if (setp) begin
      wbyte({SLV, 1'b0}, 0, a);
      chk("rd_waddr_ack", 32'(a), 32'd0);
      wbyte(pb, 0, a);
      chk("rd_ptr_ack", 32'(a), 32'd0);
      mptr = 4'(pb % 16);
      start_c();
    end
    wbyte({SLV, 1'b1}, 0, a);
    chk("rd_addr_ack", 32'(a), 32'd0);
    for (int k = 0; k < n; k++) begin
      rbyte(k == n - 1, d);
      chk("rd_data", 32'(d), 32'(mregs[mptr]));
      if (k != n - 1) mptr = 4'((int'(mptr) + 1) % 16);
    end
    stop_c();
    chk("rd_busy_off", 32'(busy), 32'd0);
  endtask

  initial begin
    logic a, s;
    int   oe0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    wclk(5);
    sys_rst = 1'b0;
    wclk(2);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    rchk(4'd0, "rst_reg0");
    rchk(4'd15, "rst_reg15");

    // burst write with auto-increment
    wd[0] = 8'hA5; wd[1] = 8'h5A;
    t_write(8'h03, 2, 0);
    rchk(4'd3, "t1_reg3");
    rchk(4'd4, "t1_reg4");

    // pointer wrap on write, then pointer-set + repeated START read across the wrap
    wd[0] = 8'h11; wd[1] = 8'h22;
    t_write(8'h0F, 2, 0);
    rchk(4'd15, "t2_reg15");
    rchk(4'd0, "t2_reg0");
    t_read(1'b1, 8'h0F, 2);

    // non-matching address: never driven, busy stays low
    oe0 = oe_cnt;
    start_c();
    wbyte({7'h51, 1'b0}, 0, a);
    chk("nomatch_nack", 32'(a), 32'd1);
    chk("nomatch_busy", 32'(busy), 32'd0);
    wbyte(8'h3C, 0, a);
    chk("nomatch_data_nack", 32'(a), 32'd1);
    stop_c();
    chk("nomatch_oe_quiet", 32'(oe_cnt - oe0), 32'd0);

    // glitches on SCL/SDA inside data bytes, then STOP mid-byte
    wd[0] = 8'hE7; wd[1] = 8'h18;
    t_write(8'h07, 2, 1);
    rchk(4'd7, "t4_reg7");
    rchk(4'd8, "t4_reg8");
    start_c();
    wbyte({SLV, 1'b0}, 0, a);
    wbyte(8'h06, 0, a);
    mptr = 4'd6;
    for (int i = 0; i < 4; i++) bit_x(1'b1, 0, s);
    stop_c();
    chk("midstop_busy", 32'(busy), 32'd0);
    rchk(4'd6, "midstop_reg6");

    // host and I2C writes on the same clock: same register, then different registers
    start_c();
    wbyte({SLV, 1'b0}, 0, a);
    wbyte(8'h03, 0, a);
    ha = 4'd3; hd = 8'h77;
    mregs[3] = 8'h77; mregs[3] = 8'hC3;
    exp_q.push_back(4'd3);
    wbyte(8'hC3, 2, a);
    chk("collide_ack", 32'(a), 32'd0);
    ha = 4'd9; hd = 8'h99;
    mregs[9] = 8'h99; mregs[4] = 8'h44;
    exp_q.push_back(4'd4);
    wbyte(8'h44, 2, a);
    stop_c();
    mptr = 4'd5;
    rchk(4'd3, "collide_reg3");
    rchk(4'd9, "collide_reg9");
    rchk(4'd4, "collide_reg4");

    // random traffic against the model
    for (int it = 0; it < 10; it++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) wd[2'(k)] = 8'($urandom);
      if (kind == 0) t_write(8'($urandom), int'($urandom_range(0, 3)), 0);
      else if (kind == 1) t_read(1'b1, 8'($urandom), int'($urandom_range(1, 3)));
      else if (kind == 2) t_read(1'b0, 8'h00, int'($urandom_range(1, 3)));
      else hwrite(4'($urandom), 8'($urandom));
    end

    // reset while the target is driving a 0 data bit
    hwrite(4'd5, 8'h3C);
    start_c();
    wbyte({SLV, 1'b0}, 0, a);
    wbyte(8'h05, 0, a);
    start_c();
    wbyte({SLV, 1'b1}, 0, a);
    chk("rd_drive_low", 32'(sda_oe), 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 4'd0;
    rchk(4'd5, "midrst_reg5");
    rchk(4'd3, "midrst_reg3");
    stop_c();

    // general-call address
    start_c();
    wbyte(8'h00, 0, a);
`ifdef I2C_GEN_CALL_EN
    chk("gc_addr_ack", 32'(a), 32'd0);
    exp_q.push_back(4'd0);
    mregs[0] = 8'h9C;
    wbyte(8'h9C, 0, a);
    chk("gc_data_ack", 32'(a), 32'd0);
    wbyte(8'h12, 0, a);
    chk("gc_extra_nack", 32'(a), 32'd1);
`else
    chk("gc_addr_nack", 32'(a), 32'd1);
    wbyte(8'h9C, 0, a);
    chk("gc_data_nack", 32'(a), 32'd1);
`endif
    stop_c();
    rchk(4'd0, "gc_reg0");

    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 4; k++) wd[2'(k)] = 8'($urandom);
      if (it % 2 == 0) t_write(8'($urandom), int'($urandom_range(1, 3)), 0);
      else t_read(1'b1, 8'($urandom), int'($urandom_range(1, 3)));
    end

    wclk(4);
    chk("pending_wr", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) rchk(4'(i), "final_reg");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
